coherence_bus_arbiter: RTL and testbench
========================================

COHERENCE_BUS_ARBITER -- requirements
Module: coherence_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default NUM_CACHE (8): number of cache requesters sharing the coherence request bus.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles spent in ARB_WAIT before forced release.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 req_i  input  NUM_REQ x req_msg_t  per-cache request (valid, source, addr, bus_tx).
REQ-006 resp_done_i  input  1  single-cycle pulse: response network has completed the current transaction.
REQ-007 gnt_o  output  NUM_REQ  one-hot grant pulse to the winning requester.
REQ-008 bus_req_o  output  req_msg_t  registered broadcast of the granted request to all snoopers and L2.
REQ-009 busy_o  output  1  high whenever state is not ARB_IDLE.
REQ-010 timeout_o  output  1  single-cycle pulse when a transaction is force-released.

Function
REQ-011 States: ARB_IDLE, ARB_BCAST, ARB_WAIT; exactly one bus transaction outstanding at any time (atomic bus).
REQ-012 Eligible requester k: req_i[k].valid=1 and req_i[k].bus_tx != NONE; valid requests with bus_tx=NONE are never granted.
REQ-013 ARB_IDLE: if any requester eligible, select winner round-robin, latch its request into bus_req_o, go ARB_BCAST; else stay.
REQ-014 Round-robin: search starts at (last_winner+1) mod NUM_REQ, wraps; last_winner updates only on a grant.
REQ-015 bus_req_o.source SHALL equal winner index k (zero-extended to $clog2(NUM_CACHE)+1 bits), overriding req_i[k].source.
REQ-016 ARB_BCAST lasts exactly one cycle: bus_req_o.valid=1 and gnt_o[k]=1 in that cycle only; next state ARB_WAIT, or ARB_IDLE if resp_done_i=1 in that cycle.
REQ-017 Requester holds req_i[k] stable until it observes gnt_o[k]=1, then deasserts valid the following cycle.
REQ-018 ARB_WAIT: on resp_done_i=1 go ARB_IDLE; bus_req_o.valid=0; addr/bus_tx/source held stable for snooper reference.
REQ-019 ARB_WAIT wait counter (8 bits) clears on entry, increments each cycle; when it equals TIMEOUT_CYCLES without resp_done_i, pulse timeout_o and go ARB_IDLE.
REQ-020 resp_done_i in ARB_IDLE is ignored; resp_done_i and timeout in the same cycle: completion wins, no timeout_o.
REQ-021 Latency: eligible request sampled in ARB_IDLE at edge t yields gnt_o/bus_req_o.valid during cycle t+1; earliest next broadcast is 2 cycles after resp_done_i.
REQ-022 All PUTM, GETS, GETM treated identically for arbitration and completion.

Reset
REQ-023 While rst_n=0 at a clock edge: state=ARB_IDLE, last_winner=NUM_REQ-1 (requester 0 highest priority), counter=0, gnt_o=0, bus_req_o=0 (bus_tx field=GETS encoding 0, valid=0), timeout_o=0, busy_o=0.
REQ-024 Reset mid-transaction aborts it; no gnt_o, timeout_o or bus_req_o.valid pulse is emitted on the cycle after reset.

Structure
REQ-025 arb_state_t enum (ARB_IDLE, ARB_BCAST, ARB_WAIT) SHALL be added to package cache_types; req_msg_t, bus_tx_t, NUM_CACHE reused from it.
REQ-026 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: eligible vector, last_winner; outputs: any, winner index).
REQ-027 All outputs registered; no combinational path from req_i or resp_done_i to any output.

Verification
REQ-028 Single request: cache 3 GETS addr 0x0000_1000 -> gnt_o=0x08, bus_req_o.valid 1 cycle, source=3; resp_done_i 5 cycles later -> busy_o low next cycle.
REQ-029 Fairness: caches 0,2,7 all GETM held continuously from reset -> grant order 0,2,7,0 across four transactions.
REQ-030 Wrap: last_winner=7, caches 1 and 6 eligible -> cache 1 granted.
REQ-031 Filter: cache 5 valid with bus_tx=NONE, none other -> no grant, busy_o stays 0.
REQ-032 Timeout: grant cache 4, never pulse resp_done_i -> timeout_o pulses 255 cycles after ARB_WAIT entry; next eligible request granted afterward.
REQ-033 Reset mid-ARB_WAIT with cache 2 pending -> all outputs zero; after release, cache 2 granted before lower-priority requesters.

Source files
------------

// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared cache-coherence bus types: request message layout, bus transaction
// encodings and the arbiter state enumeration.
package cache_types;

    localparam int NUM_CACHE = 8;
    localparam int SRC_W     = $clog2(NUM_CACHE) + 1;
    localparam int ADDR_W    = 32;

    typedef enum logic [1:0] {
        GETS = 2'd0,
        GETM = 2'd1,
        PUTM = 2'd2,
        NONE = 2'd3
    } bus_tx_t;

    typedef struct packed {
        logic              valid;
        logic [SRC_W-1:0]  source;
        logic [ADDR_W-1:0] addr;
        bus_tx_t           bus_tx;
    } req_msg_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BCAST = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    // A valid message that carries no bus transaction must never win the bus.
    function automatic logic is_eligible(input req_msg_t r);
        return r.valid && (r.bus_tx != NONE);
    endfunction

endpackage

// File: rtl/coherence_bus_arbiter_rr.sv
// Combinational round-robin picker: first eligible requester after the last winner.
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [IDX_W-1:0] last_winner_i,
    output logic             any_o,
    output logic [IDX_W-1:0] winner_o
);

    logic [IDX_W-1:0] idx;

    // Walk from last_winner+1 around to last_winner itself so it ends up lowest priority.
    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDX_W'((int'(last_winner_i) + i) % N);
            if (!any_o && eligible_i[idx]) begin
                any_o    = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Atomic coherence request bus arbiter: grants one cache at a time round-robin,
// broadcasts its request for one cycle, then waits for completion or timeout.
module coherence_bus_arbiter
    import cache_types::*;
#(
    parameter int NUM_REQ        = NUM_CACHE,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  req_msg_t [NUM_REQ-1:0] req_i,
    input  logic                   resp_done_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output req_msg_t               bus_req_o,
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam int         IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   last_winner_q, last_winner_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    req_msg_t           bus_req_q, bus_req_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] eligible;
    logic               any_eligible;
    logic [IDX_W-1:0]   winner;

    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            eligible[k] = is_eligible(req_i[k]);
        end
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .eligible_i    (eligible),
        .last_winner_i (last_winner_q),
        .any_o         (any_eligible),
        .winner_o      (winner)
    );

    // Address/command stay on the bus after the broadcast so snoopers can refer back to it.
    always_comb begin
        state_d           = state_q;
        last_winner_d     = last_winner_q;
        wait_cnt_d        = wait_cnt_q;
        gnt_d             = '0;
        bus_req_d         = bus_req_q;
        bus_req_d.valid   = 1'b0;
        timeout_d         = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (any_eligible) begin
                    state_d          = ARB_BCAST;
                    last_winner_d    = winner;
                    gnt_d[winner]    = 1'b1;
                    bus_req_d        = req_i[winner];
                    bus_req_d.source = SRC_W'(winner);
                    bus_req_d.valid  = 1'b1;
                end
            end
            ARB_BCAST: begin
                wait_cnt_d = '0;
                state_d    = resp_done_i ? ARB_IDLE : ARB_WAIT;
            end
            ARB_WAIT: begin
                if (resp_done_i) begin
                    state_d = ARB_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == TIMEOUT_VAL) begin
                        timeout_d = 1'b1;
                        state_d   = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            last_winner_q <= IDX_W'(NUM_REQ - 1);
            wait_cnt_q    <= '0;
            gnt_q         <= '0;
            bus_req_q     <= '0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            wait_cnt_q    <= wait_cnt_d;
            gnt_q         <= gnt_d;
            bus_req_q     <= bus_req_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign bus_req_o = bus_req_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Bench for coherence_bus_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of bus ownership.
module tb_coherence_bus_arbiter;
    import cache_types::*;

    localparam int N  = NUM_CACHE;
    localparam int TO = 255;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             resp_done;
    req_msg_t [N-1:0] req;
    logic [N-1:0]     gnt_o;
    req_msg_t         bus_req_o;
    logic             busy_o;
    logic             timeout_o;

    always #5 clk = ~clk;

    coherence_bus_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .resp_done_i (resp_done),
        .gnt_o       (gnt_o),
        .bus_req_o   (bus_req_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit auto_release = 1'b1;

    // Model: the bus is either free or owned since m_grant_cyc by m_winner.
    bit       m_held = 1'b0;
    int       m_grant_cyc = -1;
    int       m_winner = 0;
    int       m_last = N - 1;
    int       m_to_cyc = -1;
    req_msg_t m_bus = '0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Applies the rules at the edge that ends cycle cyc-1 and starts cycle cyc.
    task automatic modelEdge();
        if (!rst_n) begin
            m_held   = 1'b0;
            m_last   = N - 1;
            m_bus    = '0;
            m_to_cyc = -1;
        end else if (m_held) begin
            if (resp_done) begin
                m_held = 1'b0;
            end else if ((cyc - 1) - m_grant_cyc == TO) begin
                m_held   = 1'b0;
                m_to_cyc = cyc;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c = (m_last + k) % N;
                if (!m_held && req[c].valid && req[c].bus_tx != NONE) begin
                    m_held       = 1'b1;
                    m_grant_cyc  = cyc;
                    m_winner     = c;
                    m_last       = c;
                    m_bus        = req[c];
                    m_bus.source = SRC_W'(c);
                end
            end
        end
    endtask

    task automatic stepCycle();
        logic [N-1:0] exp_gnt;
        req_msg_t     exp_bus;
        bit           bcast;
        @(posedge clk);
        cyc++;
        modelEdge();
        #1;
        bcast   = m_held && (m_grant_cyc == cyc);
        exp_gnt = '0;
        if (bcast) exp_gnt[m_winner] = 1'b1;
        exp_bus       = m_bus;
        exp_bus.valid = bcast;
        checkOutput("gnt", gnt_o, exp_gnt);
        checkOutput("bus_req", bus_req_o, exp_bus);
        checkOutput("busy", busy_o, m_held);
        checkOutput("timeout", timeout_o, m_to_cyc == cyc);
        if (auto_release) begin
            for (int k = 0; k < N; k++) if (exp_gnt[k]) req[k].valid = 1'b0;
        end
    endtask

    task automatic setReq(input int k, input bus_tx_t tx, input logic [31:0] addr);
        req[k].valid  = 1'b1;
        req[k].bus_tx = tx;
        req[k].addr   = addr;
        req[k].source = SRC_W'($urandom);
    endtask

    // One full transaction: expect the grant, hold w wait cycles, then complete.
    task automatic doTxn(input string tag, input logic [N-1:0] exp, input int w);
        stepCycle();
        checkOutput(tag, gnt_o, exp);
        repeat (w) stepCycle();
        resp_done = 1'b1;
        stepCycle();
        resp_done = 1'b0;
        checkOutput({tag, "_busy"}, busy_o, 1'b0);
    endtask

    task automatic applyStimulus();
        for (int k = 0; k < N; k++) begin
            if (!req[k].valid) begin
                if ($urandom % 8 == 0) setReq(k, bus_tx_t'($urandom % 4), $urandom);
            end else if (req[k].bus_tx == NONE && $urandom % 4 == 0) begin
                req[k].valid = 1'b0;
            end
        end
        resp_done = ($urandom % 5 == 0);
        rst_n     = ($urandom % 400 != 0);
    endtask

    initial begin
        req       = '0;
        rst_n     = 1'b0;
        resp_done = 1'b0;
        repeat (3) stepCycle();
        checkOutput("rst_bus", bus_req_o, 0);
        rst_n = 1'b1;

        // Single GETS from cache 3.
        setReq(3, GETS, 32'h0000_1000);
        stepCycle();
        checkOutput("single_gnt", gnt_o, 8'h08);
        checkOutput("single_src", bus_req_o.source, 3);
        checkOutput("single_valid", bus_req_o.valid, 1);
        stepCycle();
        checkOutput("single_valid_drop", bus_req_o.valid, 0);
        checkOutput("single_addr_hold", bus_req_o.addr, 32'h0000_1000);
        repeat (4) stepCycle();
        resp_done = 1'b1;
        stepCycle();
        resp_done = 1'b0;
        checkOutput("single_busy_low", busy_o, 0);

        // Fairness with caches 0, 2, 7 requesting continuously from reset.
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        auto_release = 1'b0;
        setReq(0, GETM, 32'h100);
        setReq(2, GETM, 32'h200);
        setReq(7, GETM, 32'h700);
        doTxn("fair0", 8'h01, 3);
        doTxn("fair1", 8'h04, 2);
        doTxn("fair2", 8'h80, 1);
        doTxn("fair3", 8'h01, 0);
        req = '0;
        auto_release = 1'b1;

        // Wrap past the top index.
        setReq(7, PUTM, 32'h7000);
        doTxn("wrap_pre", 8'h80, 2);
        setReq(1, GETS, 32'h1100);
        setReq(6, GETM, 32'h6600);
        doTxn("wrap", 8'h02, 1);
        doTxn("wrap_next", 8'h40, 1);

        // NONE requests are never granted.
        req[5].valid  = 1'b1;
        req[5].bus_tx = NONE;
        repeat (10) begin
            stepCycle();
            checkOutput("filter_busy", busy_o, 0);
        end
        req = '0;

        // Timeout on cache 4, then a fresh request is served.
        setReq(4, GETM, 32'h4444);
        stepCycle();
        checkOutput("to_gnt", gnt_o, 8'h10);
        repeat (TO) stepCycle();
        checkOutput("to_early", timeout_o, 0);
        stepCycle();
        checkOutput("to_pulse", timeout_o, 1);
        checkOutput("to_busy", busy_o, 0);
        setReq(1, GETS, 32'h1111);
        stepCycle();
        checkOutput("to_next_gnt", gnt_o, 8'h02);
        checkOutput("to_single", timeout_o, 0);
        resp_done = 1'b1;
        stepCycle();
        resp_done = 1'b0;

        // Reset while cache 3 owns the bus and caches 2 and 7 wait.
        setReq(3, GETS, 32'h3333);
        stepCycle();
        checkOutput("rstw_gnt", gnt_o, 8'h08);
        repeat (3) stepCycle();
        setReq(2, GETM, 32'h2222);
        setReq(7, GETS, 32'h7777);
        rst_n = 1'b0;
        stepCycle();
        checkOutput("rstw_gnt0", gnt_o, 0);
        checkOutput("rstw_bus0", bus_req_o, 0);
        checkOutput("rstw_busy0", busy_o, 0);
        checkOutput("rstw_to0", timeout_o, 0);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("rstw_prio", gnt_o, 8'h04);

        repeat (3000) begin
            applyStimulus();
            stepCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
